// File: rtl/pifo_oq_pkg.sv
// Shared definitions for the PIFO output-queue stage.
//   - st_t        : ingress FSM state
//   - word_width  : FIFO word width for {tdata, tkeep, tuser, tlast}
//   - TLAST_BIT / TUSER_LSB : field positions inside a FIFO word
//   - tpifo_lsb   : LSB of the PIFO tag inside a FIFO word
//   - decode_dst  : destination bit array -> per-queue mask
package pifo_oq_pkg;

    // Upper bound on NUM_QUEUES supported by decode_dst.
    localparam int unsigned MAX_QUEUES = 16;

    // FIFO word layout, LSB first: tlast, tuser, tkeep, tdata.
    localparam int unsigned TLAST_BIT = 0;
    localparam int unsigned TUSER_LSB = 1;

    typedef enum logic [1:0] {
        StSop,
        StStore,
        StDrop
    } st_t;

    function automatic int unsigned word_width(input int unsigned data_width,
                                               input int unsigned tuser_width);
        return data_width + data_width / 8 + tuser_width + 1;
    endfunction

    // The PIFO tag is the top pifo_len bits of tuser.
    function automatic int unsigned tpifo_lsb(input int unsigned tuser_width,
                                              input int unsigned pifo_len);
        return TUSER_LSB + tuser_width - pifo_len;
    endfunction

    // field holds tuser bits starting at DST_POS. Even bits map to queues
    // 0..num_queues-2; all odd bits fold into the last (CPU/DMA) queue.
    function automatic logic [MAX_QUEUES-1:0] decode_dst(input logic [2*MAX_QUEUES-1:0] field,
                                                         input int unsigned num_queues);
        logic [MAX_QUEUES-1:0] dst;
        dst = '0;
        for (int unsigned i = 0; i < MAX_QUEUES - 1; i++) begin
            if (i < num_queues - 1) begin
                dst[i]              = field[2*i];
                dst[num_queues - 1] = dst[num_queues - 1] | field[2*i+1];
            end
        end
        return dst;
    endfunction

endpackage

// File: rtl/pifo_oq_fifo.sv
// Single-clock show-ahead FIFO with occupancy output.
//   clk, rst          : clock, asynchronous active-high reset (empties the FIFO)
//   wr_en, wr_data    : push; must not be asserted while full
//   rd_en             : pop request, honoured only when not empty
//   rd_data           : word at the head, valid whenever empty is low
//   empty             : no words stored
//   count             : words stored (0 .. 2^DEPTH_BITS)
module pifo_oq_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_BITS = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  empty,
    output logic [DEPTH_BITS:0]   count
);

    localparam int unsigned DEPTH = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] PTR_ONE = 1;

    logic [WIDTH-1:0]    mem [DEPTH];
    // One extra pointer bit separates full from empty.
    logic [DEPTH_BITS:0] wr_ptr_q, rd_ptr_q;
    logic                full;
    logic                pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                     (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
    assign count   = wr_ptr_q - rd_ptr_q;
    assign pop     = rd_en & ~empty;
    assign rd_data = mem[rd_ptr_q[DEPTH_BITS-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[DEPTH_BITS-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end
        end
    end

    // Admission reserve upstream makes overflow impossible.
    assert property (@(posedge clk) disable iff (rst) !(wr_en && full))
        else $error("pifo_oq_fifo: write while full");

endmodule

// File: rtl/pifo_output_queues.sv
// Per-port output queue stage for the PIFO scheduler datapath.
// Decodes the destination mask from s_axis_tuser, admits whole packets into
// one FIFO per queue (multicast copies into every admitted queue), truncates
// packets longer than MAX_PKT_WORDS, and drains each queue on its own stream.
//   axis_aclk, axis_reset : clock, asynchronous active-high reset
//   s_axis_*              : ingress stream; tready is 1 outside reset
//   m_axis_*              : per-queue egress streams, queue i in slice i;
//                           tpifo is the top PIFO_INFO_LENGTH bits of head tuser
//   q_size                : per-queue word occupancy
//   pkt_stored/dropped/removed/truncated : registered one-cycle event pulses
module pifo_output_queues
    import pifo_oq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 256,
    parameter int unsigned TUSER_WIDTH      = 160,
    parameter int unsigned PIFO_INFO_LENGTH = 32,
    parameter int unsigned NUM_QUEUES       = 5,
    parameter int unsigned DEPTH_BITS       = 6,
    parameter int unsigned MAX_PKT_WORDS    = 48,
    parameter int unsigned DST_POS          = 24
) (
    input  logic                                   axis_aclk,
    input  logic                                   axis_reset,

    input  logic [DATA_WIDTH-1:0]                  s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]                s_axis_tkeep,
    input  logic [TUSER_WIDTH-1:0]                 s_axis_tuser,
    input  logic                                   s_axis_tvalid,
    input  logic                                   s_axis_tlast,
    output logic                                   s_axis_tready,

    output logic [NUM_QUEUES*DATA_WIDTH-1:0]       m_axis_tdata,
    output logic [NUM_QUEUES*DATA_WIDTH/8-1:0]     m_axis_tkeep,
    output logic [NUM_QUEUES*TUSER_WIDTH-1:0]      m_axis_tuser,
    output logic [NUM_QUEUES*PIFO_INFO_LENGTH-1:0] m_axis_tpifo,
    output logic [NUM_QUEUES-1:0]                  m_axis_tvalid,
    output logic [NUM_QUEUES-1:0]                  m_axis_tlast,
    input  logic [NUM_QUEUES-1:0]                  m_axis_tready,

    output logic [NUM_QUEUES*(DEPTH_BITS+1)-1:0]   q_size,
    output logic [NUM_QUEUES-1:0]                  pkt_stored,
    output logic [NUM_QUEUES-1:0]                  pkt_dropped,
    output logic [NUM_QUEUES-1:0]                  pkt_removed,
    output logic [NUM_QUEUES-1:0]                  pkt_truncated
);

    localparam int unsigned WORD_W    = word_width(DATA_WIDTH, TUSER_WIDTH);
    localparam int unsigned KEEP_W    = DATA_WIDTH / 8;
    localparam int unsigned KEEP_LSB  = TUSER_LSB + TUSER_WIDTH;
    localparam int unsigned DATA_LSB  = KEEP_LSB + KEEP_W;
    localparam int unsigned PIFO_LSB  = tpifo_lsb(TUSER_WIDTH, PIFO_INFO_LENGTH);
    localparam int unsigned DST_BITS  = 2 * (NUM_QUEUES - 1);
    localparam int unsigned CNT_W     = $clog2(MAX_PKT_WORDS + 1);

    localparam logic [DEPTH_BITS:0] DEPTH_W   = 1 << DEPTH_BITS;
    localparam logic [DEPTH_BITS:0] RESERVE_W = MAX_PKT_WORDS;
    localparam logic [CNT_W-1:0]    CNT_ONE   = 1;
    localparam logic [CNT_W-1:0]    MAX_CNT   = MAX_PKT_WORDS;

    // ---------------------------------------------------------------
    // Destination decode and admission check
    // ---------------------------------------------------------------
    logic [2*MAX_QUEUES-1:0] dst_field;
    logic [MAX_QUEUES-1:0]   dst_all;
    logic [NUM_QUEUES-1:0]   dst;
    logic [NUM_QUEUES-1:0]   free_ok;
    logic [NUM_QUEUES-1:0]   admit;

    always_comb begin
        dst_field                = '0;
        dst_field[DST_BITS-1:0]  = s_axis_tuser[DST_POS +: DST_BITS];
        dst_all                  = decode_dst(dst_field, NUM_QUEUES);
        dst                      = dst_all[NUM_QUEUES-1:0];
    end

    assign admit         = dst & free_ok;
    assign s_axis_tready = ~axis_reset;

    // ---------------------------------------------------------------
    // Ingress FSM
    // ---------------------------------------------------------------
    st_t                   state_q, state_d;
    logic [NUM_QUEUES-1:0] admit_q, admit_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [NUM_QUEUES-1:0] wr_en;
    logic                  wr_last;
    logic [WORD_W-1:0]     wr_word;

    logic [NUM_QUEUES-1:0] stored_q, stored_d;
    logic [NUM_QUEUES-1:0] dropped_q, dropped_d;
    logic [NUM_QUEUES-1:0] truncated_q, truncated_d;
    logic [NUM_QUEUES-1:0] removed_q, removed_d;

    always_comb begin
        state_d     = state_q;
        admit_d     = admit_q;
        cnt_d       = cnt_q;
        wr_en       = '0;
        wr_last     = s_axis_tlast;
        stored_d    = '0;
        dropped_d   = '0;
        truncated_d = '0;

        if (s_axis_tvalid) begin
            unique case (state_q)
                StSop: begin
                    stored_d  = admit;
                    dropped_d = dst & ~free_ok;
                    if (admit != '0) begin
                        wr_en   = admit;
                        admit_d = admit;
                        cnt_d   = CNT_ONE;
                        if (!s_axis_tlast) begin
                            // A one-word limit truncates on the very first beat.
                            if (MAX_CNT == CNT_ONE) begin
                                wr_last     = 1'b1;
                                truncated_d = admit;
                                state_d     = StDrop;
                            end else begin
                                state_d = StStore;
                            end
                        end
                    end else if (!s_axis_tlast) begin
                        state_d = StDrop;
                    end
                end
                StStore: begin
                    wr_en = admit_q;
                    cnt_d = cnt_q + CNT_ONE;
                    if (s_axis_tlast) begin
                        state_d = StSop;
                    end else if (cnt_d == MAX_CNT) begin
                        wr_last     = 1'b1;
                        truncated_d = admit_q;
                        state_d     = StDrop;
                    end
                end
                StDrop: begin
                    if (s_axis_tlast) begin
                        state_d = StSop;
                    end
                end
                default: state_d = StSop;
            endcase
        end
    end

    always_ff @(posedge axis_aclk or posedge axis_reset) begin
        if (axis_reset) begin
            state_q     <= StSop;
            admit_q     <= '0;
            cnt_q       <= '0;
            stored_q    <= '0;
            dropped_q   <= '0;
            truncated_q <= '0;
            removed_q   <= '0;
        end else begin
            state_q     <= state_d;
            admit_q     <= admit_d;
            cnt_q       <= cnt_d;
            stored_q    <= stored_d;
            dropped_q   <= dropped_d;
            truncated_q <= truncated_d;
            removed_q   <= removed_d;
        end
    end

    assign pkt_stored    = stored_q;
    assign pkt_dropped   = dropped_q;
    assign pkt_truncated = truncated_q;
    assign pkt_removed   = removed_q;

    assign wr_word = {s_axis_tdata, s_axis_tkeep, s_axis_tuser, wr_last};

    // ---------------------------------------------------------------
    // Per-queue FIFOs and egress
    // ---------------------------------------------------------------
    logic [WORD_W-1:0]     head  [NUM_QUEUES];
    logic [DEPTH_BITS:0]   count [NUM_QUEUES];
    logic [NUM_QUEUES-1:0] empty;
    logic [NUM_QUEUES-1:0] pop;

    for (genvar q = 0; q < NUM_QUEUES; q++) begin : g_queue
        pifo_oq_fifo #(
            .WIDTH      (WORD_W),
            .DEPTH_BITS (DEPTH_BITS)
        ) u_fifo (
            .clk     (axis_aclk),
            .rst     (axis_reset),
            .wr_en   (wr_en[q]),
            .wr_data (wr_word),
            .rd_en   (m_axis_tready[q]),
            .rd_data (head[q]),
            .empty   (empty[q]),
            .count   (count[q])
        );

        assign pop[q]       = m_axis_tready[q] & ~empty[q];
        assign removed_d[q] = pop[q] & head[q][TLAST_BIT];
        // Credit is taken from registered occupancy only; a same-cycle pop is not counted.
        assign free_ok[q]   = (DEPTH_W - count[q]) >= RESERVE_W;

        assign m_axis_tvalid[q]                                     = ~empty[q];
        assign m_axis_tlast[q]                                      = head[q][TLAST_BIT];
        assign m_axis_tdata[q*DATA_WIDTH +: DATA_WIDTH]             = head[q][DATA_LSB +: DATA_WIDTH];
        assign m_axis_tkeep[q*KEEP_W +: KEEP_W]                     = head[q][KEEP_LSB +: KEEP_W];
        assign m_axis_tuser[q*TUSER_WIDTH +: TUSER_WIDTH]           = head[q][TUSER_LSB +: TUSER_WIDTH];
        assign m_axis_tpifo[q*PIFO_INFO_LENGTH +: PIFO_INFO_LENGTH] =
            head[q][PIFO_LSB +: PIFO_INFO_LENGTH];
        assign q_size[q*(DEPTH_BITS+1) +: DEPTH_BITS+1]             = count[q];
    end

endmodule

// File: tb/tb_pifo_output_queues.sv
module tb_pifo_output_queues;

    localparam int unsigned DW = 256;
    localparam int unsigned TW = 160;
    localparam int unsigned PL = 32;
    localparam int unsigned NQ = 5;
    localparam int unsigned DB = 6;

    logic                axis_aclk = 1'b0;
    logic                axis_reset = 1'b0;
    logic [DW-1:0]       s_axis_tdata = '0;
    logic [DW/8-1:0]     s_axis_tkeep = '0;
    logic [TW-1:0]       s_axis_tuser = '0;
    logic                s_axis_tvalid = 1'b0;
    logic                s_axis_tlast = 1'b0;
    logic                s_axis_tready;
    logic [NQ*DW-1:0]    m_axis_tdata;
    logic [NQ*DW/8-1:0]  m_axis_tkeep;
    logic [NQ*TW-1:0]    m_axis_tuser;
    logic [NQ*PL-1:0]    m_axis_tpifo;
    logic [NQ-1:0]       m_axis_tvalid;
    logic [NQ-1:0]       m_axis_tlast;
    logic [NQ-1:0]       m_axis_tready = '0;
    logic [NQ*(DB+1)-1:0] q_size;
    logic [NQ-1:0]       pkt_stored, pkt_dropped, pkt_removed, pkt_truncated;

    int checks = 0;
    int failures = 0;

    pifo_output_queues dut (
        .axis_aclk     (axis_aclk),
        .axis_reset    (axis_reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tuser  (s_axis_tuser),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tuser  (m_axis_tuser),
        .m_axis_tpifo  (m_axis_tpifo),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tready (m_axis_tready),
        .q_size        (q_size),
        .pkt_stored    (pkt_stored),
        .pkt_dropped   (pkt_dropped),
        .pkt_removed   (pkt_removed),
        .pkt_truncated (pkt_truncated)
    );

    always #5 axis_aclk = ~axis_aclk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge axis_aclk);
        #1;
    endtask

    task automatic beat(input logic [DW-1:0] d, input logic [TW-1:0] u, input logic last);
        s_axis_tdata  = d;
        s_axis_tkeep  = '1;
        s_axis_tuser  = u;
        s_axis_tlast  = last;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // dst_bits lands on tuser[31:24]; PIFO tag on tuser[159:128].
    function automatic logic [TW-1:0] mk_user(input logic [7:0] dst_bits, input logic [31:0] pifo);
        logic [TW-1:0] u;
        u          = '0;
        u[159:128] = pifo;
        u[31:24]   = dst_bits;
        u[15:0]    = pifo[15:0];
        return u;
    endfunction

    function automatic logic [DW-1:0] pat(input logic [15:0] tag, input logic [15:0] k);
        return {8{tag, k}};
    endfunction

    function automatic logic [DB:0] qs(input int q);
        return q_size[q*(DB+1) +: DB+1];
    endfunction

    function automatic logic [DW-1:0] qdata(input int q);
        return m_axis_tdata[q*DW +: DW];
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        logic [TW-1:0] u;
        int lasts;

        // Reset
        #2 axis_reset = 1'b1;
        #1;
        check("rst_tready", s_axis_tready, 1'b0);
        repeat (2) @(posedge axis_aclk);
        #1;
        check("rst_tvalid", m_axis_tvalid, 5'b0);
        check("rst_qsize", q_size, '0);
        check("rst_pulses", {pkt_stored, pkt_dropped, pkt_removed, pkt_truncated}, '0);
        axis_reset = 1'b0;
        #1;
        check("rst_tready_after", s_axis_tready, 1'b1);

        // 4-word unicast to queue 0
        u = mk_user(8'h01, 32'hA1A1_0001);
        beat(pat(16'h1, 16'd0), u, 1'b0);
        check("t1_stored", pkt_stored, 5'b00001);
        check("t1_valid", m_axis_tvalid, 5'b00001);
        check("t1_tpifo", m_axis_tpifo[31:0], 32'hA1A1_0001);
        check("t1_data", qdata(0), pat(16'h1, 16'd0));
        beat(pat(16'h1, 16'd1), u, 1'b0);
        check("t1_stored_once", pkt_stored, 5'b0);
        beat(pat(16'h1, 16'd2), u, 1'b0);
        beat(pat(16'h1, 16'd3), u, 1'b1);
        check("t1_qsize0", qs(0), 7'd4);
        check("t1_valid_only0", m_axis_tvalid, 5'b00001);
        m_axis_tready = 5'b00001;
        for (int k = 0; k < 4; k++) begin
            check("t1_pop_data", qdata(0), pat(16'h1, 16'(k)));
            check("t1_pop_last", m_axis_tlast[0], (k == 3));
            tick();
            check("t1_removed", pkt_removed[0], (k == 3));
        end
        m_axis_tready = '0;
        check("t1_drained_valid", m_axis_tvalid[0], 1'b0);
        check("t1_drained_qsize", qs(0), 7'd0);

        // Multicast: tuser[24],[25],[26] -> queues 0, 4, 1
        u = mk_user(8'h07, 32'hB2B2_0002);
        beat(pat(16'h2, 16'd0), u, 1'b0);
        check("t2_stored", pkt_stored, 5'b10011);
        for (int k = 1; k < 4; k++) beat(pat(16'h2, 16'(k)), u, (k == 3));
        check("t2_qsize0", qs(0), 7'd4);
        check("t2_qsize1", qs(1), 7'd4);
        check("t2_qsize4", qs(4), 7'd4);
        check("t2_qsize2", qs(2), 7'd0);
        check("t2_qsize3", qs(3), 7'd0);
        check("t2_data_q1", qdata(1), pat(16'h2, 16'd0));
        check("t2_tpifo_q4", m_axis_tpifo[4*PL +: PL], 32'hB2B2_0002);
        m_axis_tready = '1;
        for (int k = 0; k < 4; k++) begin
            check("t2_q4_order", qdata(4), pat(16'h2, 16'(k)));
            tick();
        end
        check("t2_all_empty", m_axis_tvalid, 5'b0);
        m_axis_tready = '0;

        // No destination: nothing stored, nothing dropped
        beat(pat(16'h9, 16'd0), mk_user(8'h00, 32'h0), 1'b1);
        check("t0_stored", pkt_stored, 5'b0);
        check("t0_dropped", pkt_dropped, 5'b0);
        check("t0_valid", m_axis_tvalid, 5'b0);

        // Admission boundary on queue 2 (tuser[28])
        u = mk_user(8'h10, 32'hC3C3_0003);
        for (int k = 0; k < 16; k++) beat(pat(16'h3, 16'(k)), u, (k == 15));
        check("t3_qsize16", qs(2), 7'd16);
        beat(pat(16'h3, 16'd16), u, 1'b1);
        check("t3_free48_stored", pkt_stored, 5'b00100);
        check("t3_free48_dropped", pkt_dropped, 5'b0);
        check("t3_qsize17", qs(2), 7'd17);
        beat(pat(16'h3, 16'd99), mk_user(8'h50, 32'hC3C3_0004), 1'b1);
        check("t3_drop_q2", pkt_dropped, 5'b00100);
        check("t3_store_q3", pkt_stored, 5'b01000);
        check("t3_qsize2_held", qs(2), 7'd17);
        check("t3_qsize3", qs(3), 7'd1);
        m_axis_tready = '1;
        repeat (17) tick();
        check("t3_drained", q_size, '0);
        m_axis_tready = '0;

        // 60-word packet to queue 1 (tuser[26]) truncated at 48
        u = mk_user(8'h04, 32'hD4D4_0004);
        for (int k = 0; k < 60; k++) begin
            beat(pat(16'h4, 16'(k)), u, (k == 59));
            if (k == 46) check("t4_trunc_early", pkt_truncated, 5'b0);
            if (k == 47) check("t4_trunc_pulse", pkt_truncated, 5'b00010);
        end
        check("t4_qsize48", qs(1), 7'd48);
        m_axis_tready = 5'b00010;
        lasts = 0;
        for (int k = 0; k < 48; k++) begin
            if (k == 47) begin
                check("t4_word48_data", qdata(1), pat(16'h4, 16'd47));
                check("t4_word48_last", m_axis_tlast[1], 1'b1);
            end
            if (m_axis_tlast[1]) lasts++;
            tick();
        end
        check("t4_single_tlast", lasts, 1);
        check("t4_qsize_empty", qs(1), 7'd0);
        m_axis_tready = '0;
        u = mk_user(8'h04, 32'hD4D4_0005);
        beat(pat(16'h5, 16'd0), u, 1'b0);
        check("t4_next_stored", pkt_stored, 5'b00010);
        beat(pat(16'h5, 16'd1), u, 1'b1);
        check("t4_next_qsize", qs(1), 7'd2);
        check("t4_next_data", qdata(1), pat(16'h5, 16'd0));

        // Reset mid-packet
        u = mk_user(8'h01, 32'hE5E5_0005);
        beat(pat(16'h6, 16'd0), u, 1'b0);
        beat(pat(16'h6, 16'd1), u, 1'b0);
        check("t5_pre_qsize0", qs(0), 7'd2);
        #2 axis_reset = 1'b1;
        #1;
        check("t5_rst_valid", m_axis_tvalid, 5'b0);
        check("t5_rst_qsize", q_size, '0);
        check("t5_rst_tready", s_axis_tready, 1'b0);
        @(posedge axis_aclk);
        #1 axis_reset = 1'b0;
        u = mk_user(8'h40, 32'hE5E5_0006);
        beat(pat(16'h7, 16'd0), u, 1'b0);
        check("t5_fresh_stored", pkt_stored, 5'b01000);
        beat(pat(16'h7, 16'd1), u, 1'b0);
        beat(pat(16'h7, 16'd2), u, 1'b1);
        check("t5_fresh_qsize3", qs(3), 7'd3);
        check("t5_fresh_qsize0", qs(0), 7'd0);
        check("t5_fresh_data", qdata(3), pat(16'h7, 16'd0));
        m_axis_tready = 5'b01000;
        repeat (3) tick();
        m_axis_tready = '0;
        check("t5_drained", q_size, '0);

        // Full-rate push and pop on queue 0
        m_axis_tready = 5'b00001;
        u = mk_user(8'h01, 32'hF6F6_0007);
        for (int k = 0; k < 10; k++) begin
            beat(pat(16'h8, 16'(k)), u, (k == 9));
            check("t6_qsize_const", qs(0), 7'd1);
            check("t6_order", qdata(0), pat(16'h8, 16'(k)));
        end
        tick();
        check("t6_removed", pkt_removed, 5'b00001);
        check("t6_empty", qs(0), 7'd0);
        m_axis_tready = '0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
